// File: rtl/tdl_therm_decoder.sv
// Tapped-delay-line TDC read side: captures the carry-chain thermometer code, detects
// hit edges, ones-counts the code into a fine time and tags it with a coarse count.
module tdl_therm_decoder #(
  parameter int TAPS        = 64,
  parameter int FINE_W      = 7,
  parameter int COARSE_W    = 16,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [TAPS-1:0]     taps,
  output logic                out_valid,
  output logic [COARSE_W-1:0] out_coarse,
  output logic [FINE_W-1:0]   out_fine,
  output logic                out_sat,
  output logic                hit_drop,
  output logic                coarse_wrap
);

  localparam int GROUPS = TAPS / 4;

  typedef enum logic [1:0] {st_disabled, st_armed, st_dead} state_t;

  logic [TAPS-1:0]     cap_reg;
  logic                cap_vld_reg;
  logic [TAPS-1:0]     syn_reg;
  logic                syn_vld_reg;
  logic                prev0_reg;
  logic [COARSE_W-1:0] cnt_reg;

  state_t              state_reg, state_next;
  logic [3:0]          dcnt_reg, dcnt_next;
  logic                hit;
  logic                accept;
  logic                drop;

  logic [2:0]          gsum_next [GROUPS];
  logic [2:0]          gsum_reg  [GROUPS];
  logic                s2_vld_reg;
  logic [COARSE_W-1:0] s2_coarse_reg;
  logic [FINE_W-1:0]   fine_sum;

  // Capture and one synchroniser stage; the valid bits mark slots that hold a real
  // post-reset sample, so the first sample is compared against a high "previous" bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_reg     <= '0;
      cap_vld_reg <= 1'b0;
      syn_reg     <= '0;
      syn_vld_reg <= 1'b0;
      prev0_reg   <= 1'b1;
    end else begin
      cap_reg     <= taps;
      cap_vld_reg <= 1'b1;
      syn_reg     <= cap_reg;
      syn_vld_reg <= cap_vld_reg;
      prev0_reg   <= syn_vld_reg ? syn_reg[0] : 1'b1;
    end
  end

  assign hit = syn_vld_reg & syn_reg[0] & ~prev0_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      coarse_wrap <= 1'b0;
    end else begin
      cnt_reg     <= cnt_reg + 1'b1;
      coarse_wrap <= &cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= st_disabled;
      dcnt_reg  <= '0;
      hit_drop  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      hit_drop  <= drop;
    end
  end

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      st_disabled: begin
        drop = hit;
        if (en) state_next = st_armed;
      end
      st_armed: begin
        if (hit) begin
          accept     = 1'b1;
          dcnt_next  = 4'(DEAD_CYCLES);
          state_next = st_dead;
        end else if (!en) begin
          state_next = st_disabled;
        end
      end
      st_dead: begin
        drop      = hit;
        dcnt_next = dcnt_reg - 1'b1;
        // Leaving on the last count keeps the suppression window at DEAD_CYCLES cycles.
        if (dcnt_reg <= 4'd1) state_next = en ? st_armed : st_disabled;
      end
      default: state_next = st_disabled;
    endcase
  end

  generate
    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
      assign gsum_next[gi] = 3'(syn_reg[4*gi])   + 3'(syn_reg[4*gi+1])
                           + 3'(syn_reg[4*gi+2]) + 3'(syn_reg[4*gi+3]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_reg    <= 1'b0;
      s2_coarse_reg <= '0;
      for (int i = 0; i < GROUPS; i++) gsum_reg[i] <= '0;
    end else begin
      s2_vld_reg    <= accept;
      s2_coarse_reg <= cnt_reg;
      for (int i = 0; i < GROUPS; i++) gsum_reg[i] <= gsum_next[i];
    end
  end

  // Plain popcount of the group sums: bubbles shift the result by their count only.
  always_comb begin
    fine_sum = '0;
    for (int i = 0; i < GROUPS; i++) fine_sum = fine_sum + FINE_W'(gsum_reg[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_coarse <= '0;
      out_fine   <= '0;
      out_sat    <= 1'b0;
    end else begin
      out_valid <= s2_vld_reg;
      if (s2_vld_reg) begin
        out_coarse <= s2_coarse_reg;
        out_fine   <= fine_sum;
        out_sat    <= (fine_sum == FINE_W'(TAPS));
      end
    end
  end

endmodule
